// File: rtl/region_decoder.sv
// CPU address-region decoder: a programmable table of {base, width, wait, en}
// entries selects one chip-select per access, then inserts wait states or a bus-error timeout.
module region_decoder #(
  parameter int NREG    = 16,
  parameter int AW      = 24,
  parameter int WAITW   = 4,
  parameter int TIMEOUT = 64,
  localparam int IW     = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    cpu_a,
  input  logic             cpu_as_n,
  input  logic             cfg_we,
  input  logic [IW-1:0]    cfg_idx,
  input  logic [AW-1:0]    cfg_base,
  input  logic [4:0]       cfg_width,
  input  logic [WAITW-1:0] cfg_wait,
  input  logic             cfg_en,
  output logic [NREG-1:0]  cs,
  output logic [IW-1:0]    hit_idx,
  output logic             dtack_n,
  output logic             berr_n,
  output logic             busy
);

  // One counter serves both the wait-state count and the unmapped timeout.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int CW = (WAITW > TW) ? WAITW : TW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_WAIT,
    S_ACK,
    S_NOHIT,
    S_ERR
  } state_e;

  logic [AW-1:0]    base_q  [NREG];
  logic [4:0]       width_q [NREG];
  logic [WAITW-1:0] wait_q  [NREG];
  logic [NREG-1:0]  en_q;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREG-1:0] cs_q, cs_d;
  logic [IW-1:0]   hit_idx_q, hit_idx_d;
  logic            dtack_n_q, dtack_n_d;
  logic            berr_n_q, berr_n_d;
  logic            busy_q, busy_d;

  logic            hit_found;
  logic [IW-1:0]   hit_sel;

  // Scanning downward lets the lowest matching index win on overlap.
  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    hit_found = 1'b0;
    hit_sel   = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (en_q[i] && (((cpu_a ^ base_q[i]) >> width_q[i]) == '0)) begin
        hit_found = 1'b1;
        hit_sel   = IW'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cs_d      = cs_q;
    hit_idx_d = hit_idx_q;
    dtack_n_d = dtack_n_q;
    berr_n_d  = berr_n_q;
    unique case (state_q)
      S_IDLE: begin
        cs_d      = '0;
        hit_idx_d = '0;
        dtack_n_d = 1'b1;
        berr_n_d  = 1'b1;
        if (!cpu_as_n) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (cpu_as_n) begin
          state_d = S_IDLE;
        end else if (hit_found) begin
          cs_d          = '0;
          cs_d[hit_sel] = 1'b1;
          hit_idx_d     = hit_sel;
          cnt_d         = CW'(wait_q[hit_sel]);
          state_d       = S_WAIT;
        end else begin
          cnt_d   = CW'(TIMEOUT - 1);
          state_d = S_NOHIT;
        end
      end
      S_WAIT, S_NOHIT: begin
        if (cpu_as_n) begin
          cs_d      = '0;
          hit_idx_d = '0;
          state_d   = S_IDLE;
        end else if (cnt_q == '0) begin
          if (state_q == S_WAIT) begin
            dtack_n_d = 1'b0;
            state_d   = S_ACK;
          end else begin
            berr_n_d = 1'b0;
            state_d  = S_ERR;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_ACK, S_ERR: begin
        if (cpu_as_n) begin
          cs_d      = '0;
          hit_idx_d = '0;
          dtack_n_d = 1'b1;
          berr_n_d  = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the table is reset explicitly because every entry must come up disabled and zeroed.
      for (int i = 0; i < NREG; i++) begin
        base_q[i]  <= '0;
        width_q[i] <= '0;
        wait_q[i]  <= '0;
      end
      en_q      <= '0;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      cs_q      <= '0;
      hit_idx_q <= '0;
      dtack_n_q <= 1'b1;
      berr_n_q  <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      if (cfg_we && (int'(cfg_idx) < NREG)) begin
        base_q[cfg_idx]  <= cfg_base;
        width_q[cfg_idx] <= cfg_width;
        wait_q[cfg_idx]  <= cfg_wait;
        en_q[cfg_idx]    <= cfg_en;
      end
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cs_q      <= cs_d;
      hit_idx_q <= hit_idx_d;
      dtack_n_q <= dtack_n_d;
      berr_n_q  <= berr_n_d;
      busy_q    <= busy_d;
    end
  end

  assign cs      = cs_q;
  assign hit_idx = hit_idx_q;
  assign dtack_n = dtack_n_q;
  assign berr_n  = berr_n_q;
  assign busy    = busy_q;

endmodule
